// File: rtl/rndswitch_pkg.sv
// Shared types and constants for the rndswitch masking scheduler.
// Optional feature macro used by the top: RNDSWITCH_FORCE_ON_EN.
`ifndef BITMAP_NB_SEGMENTS
`define BITMAP_NB_SEGMENTS 8
`endif
`ifndef RNDSIZE
`define RNDSIZE 8
`endif

package rndswitch_pkg;

  typedef enum logic [0:0] {
    GEN = 1'b0,
    RUN = 1'b1
  } sched_state_t;

  localparam int LFSR_W = 32;
  // x^32+x^22+x^2+x+1 in right-shifting Galois form
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 32'h8020_0003;
  localparam int GEN_W = $clog2(`RNDSIZE + 1);

endpackage

// File: rtl/rndswitch.sv
// Masking datapath for the segment bitmap: o = (s & r) ^ z.
`ifndef BITMAP_NB_SEGMENTS
`define BITMAP_NB_SEGMENTS 8
`endif
`ifndef RNDSIZE
`define RNDSIZE 8
`endif

module rndswitch (
  input  logic [`BITMAP_NB_SEGMENTS-1:0] s,
  input  logic [`RNDSIZE-1:0]            r,
  input  logic                           z,
  output logic [`BITMAP_NB_SEGMENTS-1:0] o
);

  assign o = (s & r[`BITMAP_NB_SEGMENTS-1:0]) ^ {`BITMAP_NB_SEGMENTS{z}};

endmodule

// File: rtl/rndswitch_lfsr.sv
// Galois LFSR: seed load (zero seed replaced by 1), shift enable, 1-bit output.
module rndswitch_lfsr
  import rndswitch_pkg::*;
(
  input  logic              clk,
  input  logic              load,
  input  logic [LFSR_W-1:0] seed,
  input  logic              shift,
  output logic              bit_out
);

  logic [LFSR_W-1:0] lfsr;

  always_ff @(posedge clk) begin
    if (load) begin
      lfsr <= (seed == '0) ? LFSR_W'(1) : seed;
    end else if (shift) begin
      lfsr <= (lfsr >> 1) ^ (lfsr[0] ? LFSR_TAPS : '0);
    end
  end

  assign bit_out = lfsr[0];

endmodule

// File: rtl/rndswitch_sched.sv
// Mask-epoch scheduler: regenerates r/z from the LFSR, then streams frames through rndswitch.
// Optional macro RNDSWITCH_FORCE_ON_EN adds force_on (all-ones mask to the datapath).
`ifndef BITMAP_NB_SEGMENTS
`define BITMAP_NB_SEGMENTS 8
`endif
`ifndef RNDSIZE
`define RNDSIZE 8
`endif

module rndswitch_sched
  import rndswitch_pkg::*;
#(
  parameter  int FRAMES_PER_MASK = 8,
  localparam int CNT_W           = $clog2(FRAMES_PER_MASK + 1)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [LFSR_W-1:0]              cfg_seed,
  input  logic                           rekey,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [`BITMAP_NB_SEGMENTS-1:0] in_s,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [`BITMAP_NB_SEGMENTS-1:0] out_o,
  output logic                           busy_gen
`ifdef RNDSWITCH_FORCE_ON_EN
  ,
  input  logic                           force_on
`endif
);

  sched_state_t                  state, state_nxt;
  logic [GEN_W-1:0]              gen_idx;
  logic [`RNDSIZE-1:0]           r_sh, r_q, r_sel;
  logic                          z_q;
  logic [`BITMAP_NB_SEGMENTS-1:0] s_q;
  logic [CNT_W-1:0]              cnt;
  logic                          rekey_pend;
  logic                          lfsr_bit, gen_done, last_out, accept, drain, idle_regen;

  rndswitch_lfsr u_lfsr (
    .clk     (clk),
    .load    (rst),
    .seed    (cfg_seed),
    .shift   (state == GEN),
    .bit_out (lfsr_bit)
  );

  assign gen_done   = (state == GEN) && (gen_idx == GEN_W'(`RNDSIZE));
  assign last_out   = (cnt == CNT_W'(FRAMES_PER_MASK - 1)) || rekey_pend;
  assign idle_regen = (state == RUN) && !out_valid && rekey_pend;
  assign accept     = in_valid && in_ready;
  assign drain      = out_valid && out_ready;

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy_gen  = 1'b0;
    case (state)
      GEN: begin
        busy_gen = 1'b1;
        if (gen_done) state_nxt = RUN;
      end
      RUN: begin
        if (idle_regen) begin
          state_nxt = GEN;
        end else begin
          in_ready = !out_valid || (out_ready && !last_out);
          if (drain && last_out) state_nxt = GEN;
        end
      end
      default: state_nxt = GEN;
    endcase
  end

  // The mask is assembled in r_sh so the live r_q/z_q only change when RUN is entered
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= GEN;
      gen_idx    <= '0;
      r_sh       <= '0;
      r_q        <= '0;
      z_q        <= 1'b0;
      s_q        <= '0;
      cnt        <= '0;
      rekey_pend <= 1'b0;
      out_valid  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == GEN) begin
        rekey_pend <= 1'b0;
        cnt        <= '0;
        if (gen_done) begin
          gen_idx <= '0;
          r_q     <= r_sh;
          z_q     <= lfsr_bit;
        end else begin
          gen_idx <= gen_idx + GEN_W'(1);
          r_sh    <= {lfsr_bit, r_sh[`RNDSIZE-1:1]};
        end
      end else begin
        if (accept) s_q <= in_s;
        if (drain) begin
          out_valid <= accept;
          if (last_out) begin
            cnt        <= '0;
            rekey_pend <= 1'b0;
          end else begin
            cnt        <= cnt + CNT_W'(1);
            rekey_pend <= rekey_pend || rekey;
          end
        end else begin
          if (accept) out_valid <= 1'b1;
          if (idle_regen) begin
            cnt        <= '0;
            rekey_pend <= 1'b0;
          end else begin
            rekey_pend <= rekey_pend || rekey;
          end
        end
      end
    end
  end

`ifdef RNDSWITCH_FORCE_ON_EN
  assign r_sel = force_on ? '1 : r_q;
`else
  assign r_sel = r_q;
`endif

  rndswitch u_rndswitch (
    .s (s_q),
    .r (r_sel),
    .z (z_q),
    .o (out_o)
  );

endmodule

// File: tb/tb_rndswitch_sched.sv
// Self-checking bench for rndswitch_sched: epoch-level reference model plus directed pins.
`ifndef BITMAP_NB_SEGMENTS
`define BITMAP_NB_SEGMENTS 8
`endif
`ifndef RNDSIZE
`define RNDSIZE 8
`endif

module tb_rndswitch_sched;

  localparam int NB     = `BITMAP_NB_SEGMENTS;
  localparam int RS     = `RNDSIZE;
  localparam int FPM    = 3;
  localparam int GENLEN = RS + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [31:0]   cfg_seed = 32'h0;
  logic          rekey = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [NB-1:0] in_s = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [NB-1:0] out_o;
  logic          busy_gen;
  logic          force_eff;
`ifdef RNDSWITCH_FORCE_ON_EN
  logic          force_on = 1'b0;
  assign force_eff = force_on;
`else
  assign force_eff = 1'b0;
`endif

  int total = 0;
  int bad   = 0;
  bit last_hs;

  always #5 clk = ~clk;

  rndswitch_sched #(.FRAMES_PER_MASK(FPM)) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_seed  (cfg_seed),
    .rekey     (rekey),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_s      (in_s),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_o     (out_o),
    .busy_gen  (busy_gen)
`ifdef RNDSWITCH_FORCE_ON_EN
    ,
    .force_on  (force_on)
`endif
  );

  // Reference model: a mask is drawn in one go when its generation period ends
  bit          m_valid = 0;
  logic [31:0] m_lfsr;
  logic [RS-1:0] m_r;
  logic        m_z;
  logic [NB-1:0] m_frame;
  bit          m_full;
  int          m_sent;
  bit          m_rekey;
  int          m_gen_left;

  function automatic logic [31:0] lfsrNext(input logic [31:0] v);
    return (v >> 1) ^ (v[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  function automatic bit modelLast();
    return (m_sent == FPM - 1) || m_rekey;
  endfunction

  function automatic bit modelInReady();
    if (m_gen_left > 0) return 1'b0;
    if (!m_full && m_rekey) return 1'b0;
    return !m_full || (out_ready && !modelLast());
  endfunction

  function automatic logic [NB-1:0] modelOut();
    logic [NB-1:0] mask;
    mask = force_eff ? {NB{1'b1}} : m_r[NB-1:0];
    return (m_frame & mask) ^ {NB{m_z}};
  endfunction

  always @(posedge clk) begin
    bit acc, drn, last;
    acc  = in_valid && modelInReady();
    drn  = m_full && out_ready;
    last = modelLast();
    if (rst) begin
      m_valid    = 1;
      m_lfsr     = (cfg_seed == 0) ? 32'h1 : cfg_seed;
      m_r        = '0;
      m_z        = 1'b0;
      m_frame    = '0;
      m_full     = 0;
      m_sent     = 0;
      m_rekey    = 0;
      m_gen_left = GENLEN;
    end else if (m_gen_left > 0) begin
      m_rekey    = 0;
      m_gen_left = m_gen_left - 1;
      if (m_gen_left == 0) begin
        for (int i = 0; i < RS; i++) begin
          m_r[i] = m_lfsr[0];
          m_lfsr = lfsrNext(m_lfsr);
        end
        m_z    = m_lfsr[0];
        m_lfsr = lfsrNext(m_lfsr);
      end
    end else if (!m_full && m_rekey) begin
      m_rekey    = 0;
      m_sent     = 0;
      m_gen_left = GENLEN;
    end else begin
      if (acc) m_frame = in_s;
      if (drn && last) begin
        m_full     = 0;
        m_sent     = 0;
        m_rekey    = 0;
        m_gen_left = GENLEN;
      end else begin
        if (drn) m_sent = m_sent + 1;
        m_full  = acc || (m_full && !drn);
        m_rekey = m_rekey || rekey;
      end
    end
  end

  task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput();
    if (!m_valid) return;
    checkValue("busy_gen", 32'(busy_gen), 32'(m_gen_left > 0));
    checkValue("out_valid", 32'(out_valid), 32'(m_full));
    checkValue("in_ready", 32'(in_ready), 32'(modelInReady()));
    checkValue("out_o", 32'(out_o), 32'(modelOut()));
    if (m_gen_left == 0) begin
      checkValue("r_q", 32'(dut.r_q), 32'(m_r));
      checkValue("z_q", 32'(dut.z_q), 32'(m_z));
    end
  endtask

  // Inputs change 1 time unit after the active edge; outputs are checked on the falling edge
  task automatic applyStimulus(input bit r, input bit rk, input bit iv,
                               input logic [NB-1:0] s, input bit ordy);
    rst       = r;
    rekey     = rk;
    in_valid  = iv;
    in_s      = s;
    out_ready = ordy;
    @(negedge clk);
    checkOutput();
    last_hs = out_valid && out_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic resetAndWaitReady(input logic [31:0] seed, input string name);
    int cyc;
    cfg_seed = seed;
    repeat (2) applyStimulus(1, 0, 1, NB'($urandom), 1);
    cyc = 0;
    while (in_ready !== 1'b1 && cyc < 50) begin
      applyStimulus(0, 0, 1, {NB{1'b1}}, 1);
      cyc++;
    end
    checkValue(name, 32'(cyc), 32'(GENLEN));
  endtask

  initial begin
    int hs, k;

    // Reset values
    cfg_seed = 32'hACE1;
    repeat (3) applyStimulus(1, 0, 1, NB'($urandom), 1);
    checkValue("rst_busy_gen", 32'(busy_gen), 32'd1);
    checkValue("rst_out_valid", 32'(out_valid), 32'd0);
    checkValue("rst_in_ready", 32'(in_ready), 32'd0);
    checkValue("rst_out_o", 32'(out_o), 32'd0);
    k = 0;
    while (in_ready !== 1'b1 && k < 50) begin
      applyStimulus(0, 0, 1, NB'($urandom), 1);
      k++;
    end
    checkValue("gen_len_seed_ace1", 32'(k), 32'(GENLEN));
    repeat (12) applyStimulus(0, 0, 1, NB'($urandom), 1);

    // Zero seed behaves as seed 1: first mask r=0xDB, z=0 with the default 8-bit mask
    resetAndWaitReady(32'h0, "gen_len_seed0");
    applyStimulus(0, 0, 1, {NB{1'b1}}, 1);
    if (RS == 8 && NB == 8) begin
      checkValue("seed0_first_frame", 32'(out_o), 32'hDB);
      checkValue("seed0_r_q", 32'(dut.r_q), 32'hDB);
      checkValue("seed0_z_q", 32'(dut.z_q), 32'h0);
    end

    // Full-throughput epoch: FPM frames, then exactly GENLEN cycles of regeneration
    hs = 0;
    k  = 0;
    while (busy_gen !== 1'b1 && k < 20) begin
      applyStimulus(0, 0, 1, {NB{1'b1}}, 1);
      hs += int'(last_hs);
      k++;
    end
    checkValue("epoch_frames", 32'(hs), 32'(FPM));
    k = 0;
    while (busy_gen === 1'b1 && k < 30) begin
      applyStimulus(0, 0, 1, {NB{1'b1}}, 1);
      k++;
    end
    checkValue("gen_len_epoch2", 32'(k), 32'(GENLEN));

    // Backpressure: frame held for 5 cycles
    applyStimulus(0, 0, 1, NB'(8'h3C), 0);
    repeat (5) applyStimulus(0, 0, 1, NB'($urandom), 0);
    checkValue("stall_in_ready", 32'(in_ready), 32'd0);
    repeat (4) applyStimulus(0, 0, 1, NB'($urandom), 1);

    // Reset mid-RUN drops the frame in flight
    applyStimulus(0, 0, 1, NB'($urandom), 0);
    applyStimulus(1, 0, 1, NB'($urandom), 0);
    checkValue("rst_midrun_valid", 32'(out_valid), 32'd0);

    // Rekey while the first frame waits: epoch ends after that frame
    resetAndWaitReady(32'h1, "gen_len_seed1");
    applyStimulus(0, 0, 1, NB'($urandom), 0);
    applyStimulus(0, 1, 1, NB'($urandom), 0);
    hs = 0;
    k  = 0;
    while (busy_gen !== 1'b1 && k < 20) begin
      applyStimulus(0, 0, 1, NB'($urandom), 1);
      hs += int'(last_hs);
      k++;
    end
    checkValue("rekey_epoch_frames", 32'(hs), 32'd1);

    // Rekey during regeneration is absorbed: next epoch is a full one
    applyStimulus(0, 1, 1, NB'($urandom), 1);
    k = 0;
    while (busy_gen === 1'b1 && k < 30) begin
      applyStimulus(0, 0, 1, NB'($urandom), 1);
      k++;
    end
    hs = 0;
    k  = 0;
    while (busy_gen !== 1'b1 && k < 20) begin
      applyStimulus(0, 0, 1, NB'($urandom), 1);
      hs += int'(last_hs);
      k++;
    end
    checkValue("gen_rekey_ignored", 32'(hs), 32'(FPM));

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      bit r;
      r = ($urandom_range(0, 299) == 0);
      if (r) cfg_seed = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
`ifdef RNDSWITCH_FORCE_ON_EN
      force_on = ($urandom_range(0, 3) == 0);
`endif
      applyStimulus(r, $urandom_range(0, 24) == 0, $urandom_range(0, 9) < 7,
                    NB'($urandom), $urandom_range(0, 9) < 6);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
